darkbus_arbiter: RTL and testbench

//  Two-master, one-slave data-bus arbiter/sequencer for the darkriscv SoC. It shares one

---
 rtl/darkbus_pkg.sv | 27 ++
 rtl/darkbus_rr_pick.sv | 20 ++
 rtl/darkbus_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_darkbus_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/darkbus_pkg.sv
// rtl/darkbus_pkg.sv - shared types and constants for the darkbus arbiter
package darkbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef logic owner_t;

    localparam owner_t OWNER_M0 = 1'b0;
    localparam owner_t OWNER_M1 = 1'b1;

    localparam logic [31:0] DARKBUS_ERRDATA = 32'hDEADBEEF;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    // A request with both strobes set is treated as a write.
    function automatic op_e req_op(input logic rd, input logic wr);
        return (wr || !rd) ? OP_WR : OP_RD;
    endfunction

endpackage

// File: rtl/darkbus_rr_pick.sv
// rtl/darkbus_rr_pick.sv - combinational two-way round-robin picker
module darkbus_rr_pick
    import darkbus_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       grant_o,
    output logic       valid_o
);

    always_comb begin
        valid_o = |req_i;
        if (&req_i) begin
            grant_o = ~last_i;
        end else begin
            grant_o = req_i[1];
        end
    end

endmodule

// File: rtl/darkbus_arbiter.sv
// rtl/darkbus_arbiter.sv - two-master, one-slave data-bus arbiter/sequencer
module darkbus_arbiter
    import darkbus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter logic [31:0] ERRDATA = DARKBUS_ERRDATA
) (
    input  logic        CLK,
    input  logic        RES,

    input  logic        M0_RD,
    input  logic        M0_WR,
    input  logic [3:0]  M0_BE,
    input  logic [31:0] M0_ADDR,
    input  logic [31:0] M0_DATAO,
    output logic [31:0] M0_DATAI,
    output logic        M0_ACK,

    input  logic        M1_RD,
    input  logic        M1_WR,
    input  logic [3:0]  M1_BE,
    input  logic [31:0] M1_ADDR,
    input  logic [31:0] M1_DATAO,
    output logic [31:0] M1_DATAI,
    output logic        M1_ACK,

    output logic        S_RD,
    output logic        S_WR,
    output logic [3:0]  S_BE,
    output logic [31:0] S_ADDR,
    output logic [31:0] S_DATAO,
    input  logic [31:0] S_DATAI,
    input  logic        S_ACK,

    output logic        GNT,
    output logic        BUS_ERR
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT);

    state_e           state_q, state_d;
    owner_t           owner_q, owner_d;
    owner_t           last_q, last_d;
    logic             s_rd_q, s_rd_d;
    logic             s_wr_q, s_wr_d;
    logic [3:0]       s_be_q, s_be_d;
    logic [31:0]      s_addr_q, s_addr_d;
    logic [31:0]      s_datao_q, s_datao_d;
    logic [31:0]      m0_datai_q, m0_datai_d;
    logic [31:0]      m1_datai_q, m1_datai_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]  req;
    logic        pick_grant;
    logic        pick_valid;
    op_e         pick_op;
    logic        timeout_hit;
    logic        slave_done;
    logic [31:0] resp_data;

    assign req = {M1_RD | M1_WR, M0_RD | M0_WR};

    darkbus_rr_pick u_pick (
        .req_i   (req),
        .last_i  (last_q),
        .grant_o (pick_grant),
        .valid_o (pick_valid)
    );

    assign pick_op     = pick_grant ? req_op(M1_RD, M1_WR) : req_op(M0_RD, M0_WR);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    // A real acknowledge wins over a timeout that expires in the same cycle.
    assign slave_done  = S_ACK || timeout_hit;
    assign resp_data   = S_ACK ? S_DATAI : ERRDATA;

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pick_valid) state_d = ST_BUSY;
            ST_BUSY: if (slave_done) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        M0_ACK  = 1'b0;
        M1_ACK  = 1'b0;
        BUS_ERR = 1'b0;
        if (state_q == ST_RESP) begin
            M0_ACK  = (owner_q == OWNER_M0);
            M1_ACK  = (owner_q == OWNER_M1);
            BUS_ERR = err_q;
        end
    end

    always_comb begin
        owner_d    = owner_q;
        last_d     = last_q;
        s_rd_d     = s_rd_q;
        s_wr_d     = s_wr_q;
        s_be_d     = s_be_q;
        s_addr_d   = s_addr_q;
        s_datao_d  = s_datao_q;
        m0_datai_d = m0_datai_q;
        m1_datai_d = m1_datai_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    owner_d   = pick_grant;
                    s_rd_d    = (pick_op == OP_RD);
                    s_wr_d    = (pick_op == OP_WR);
                    s_be_d    = pick_grant ? M1_BE    : M0_BE;
                    s_addr_d  = pick_grant ? M1_ADDR  : M0_ADDR;
                    s_datao_d = pick_grant ? M1_DATAO : M0_DATAO;
                    err_d     = 1'b0;
                    cnt_d     = '0;
                end
            end
            ST_BUSY: begin
                if (slave_done) begin
                    s_rd_d = 1'b0;
                    s_wr_d = 1'b0;
                    err_d  = !S_ACK;
                    if (s_rd_q) begin
                        if (owner_q == OWNER_M1) begin
                            m1_datai_d = resp_data;
                        end else begin
                            m0_datai_d = resp_data;
                        end
                    end
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                last_d = owner_q;
            end
            default: ;
        endcase
    end

    // Reset leaves M1 as last served so that M0 wins the first tie.
    always_ff @(posedge CLK) begin
        if (RES) begin
            owner_q    <= OWNER_M0;
            last_q     <= OWNER_M1;
            s_rd_q     <= 1'b0;
            s_wr_q     <= 1'b0;
            s_be_q     <= '0;
            s_addr_q   <= '0;
            s_datao_q  <= '0;
            m0_datai_q <= '0;
            m1_datai_q <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            owner_q    <= owner_d;
            last_q     <= last_d;
            s_rd_q     <= s_rd_d;
            s_wr_q     <= s_wr_d;
            s_be_q     <= s_be_d;
            s_addr_q   <= s_addr_d;
            s_datao_q  <= s_datao_d;
            m0_datai_q <= m0_datai_d;
            m1_datai_q <= m1_datai_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign S_RD     = s_rd_q;
    assign S_WR     = s_wr_q;
    assign S_BE     = s_be_q;
    assign S_ADDR   = s_addr_q;
    assign S_DATAO  = s_datao_q;
    assign M0_DATAI = m0_datai_q;
    assign M1_DATAI = m1_datai_q;
    assign GNT      = owner_q;

endmodule

// File: tb/tb_darkbus_arbiter.sv
// tb/tb_darkbus_arbiter.sv - self-checking bench for darkbus_arbiter
module tb_darkbus_arbiter;

    localparam int          TO   = 16;
    localparam logic [31:0] ERRD = 32'hDEADBEEF;

    logic        CLK = 1'b0;
    logic        RES = 1'b1;
    logic        M0_RD = 1'b0, M0_WR = 1'b0;
    logic [3:0]  M0_BE = 4'h0;
    logic [31:0] M0_ADDR = '0, M0_DATAO = '0;
    logic [31:0] M0_DATAI;
    logic        M0_ACK;
    logic        M1_RD = 1'b0, M1_WR = 1'b0;
    logic [3:0]  M1_BE = 4'h0;
    logic [31:0] M1_ADDR = '0, M1_DATAO = '0;
    logic [31:0] M1_DATAI;
    logic        M1_ACK;
    logic        S_RD, S_WR;
    logic [3:0]  S_BE;
    logic [31:0] S_ADDR, S_DATAO;
    logic [31:0] S_DATAI = '0;
    logic        S_ACK = 1'b0;
    logic        GNT, BUS_ERR;

    always #5 CLK = ~CLK;

    darkbus_arbiter #(.TIMEOUT(TO), .ERRDATA(ERRD)) dut (
        .CLK(CLK), .RES(RES),
        .M0_RD(M0_RD), .M0_WR(M0_WR), .M0_BE(M0_BE), .M0_ADDR(M0_ADDR),
        .M0_DATAO(M0_DATAO), .M0_DATAI(M0_DATAI), .M0_ACK(M0_ACK),
        .M1_RD(M1_RD), .M1_WR(M1_WR), .M1_BE(M1_BE), .M1_ADDR(M1_ADDR),
        .M1_DATAO(M1_DATAO), .M1_DATAI(M1_DATAI), .M1_ACK(M1_ACK),
        .S_RD(S_RD), .S_WR(S_WR), .S_BE(S_BE), .S_ADDR(S_ADDR),
        .S_DATAO(S_DATAO), .S_DATAI(S_DATAI), .S_ACK(S_ACK),
        .GNT(GNT), .BUS_ERR(BUS_ERR)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%08h, required 0x%08h", name, $time, act, exp);
        end
    endtask

    // Transaction-level reference: one access in flight, its wait count, and a pending answer.
    bit          m_active, m_resp, m_err, m_who, m_last, m_wr;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_dout;
    int          m_waited;
    logic [31:0] m_datai [2];
    logic        mreq0, mreq1, mpick;

    assign mreq0 = M0_RD | M0_WR;
    assign mreq1 = M1_RD | M1_WR;
    assign mpick = (mreq0 && mreq1) ? !m_last : mreq1;

    always @(posedge CLK) begin
        if (RES) begin
            m_active <= 1'b0; m_resp <= 1'b0; m_err <= 1'b0;
            m_last <= 1'b1; m_who <= 1'b0;
            m_datai[0] <= '0; m_datai[1] <= '0;
        end else if (m_resp) begin
            m_resp <= 1'b0;
            m_last <= m_who;
        end else if (m_active) begin
            if (S_ACK || (TO != 0 && m_waited == TO)) begin
                m_active <= 1'b0;
                m_resp   <= 1'b1;
                m_err    <= !S_ACK;
                if (!m_wr) m_datai[m_who] <= S_ACK ? S_DATAI : ERRD;
            end else begin
                m_waited <= m_waited + 1;
            end
        end else if (mreq0 || mreq1) begin
            m_active <= 1'b1;
            m_waited <= 0;
            m_who    <= mpick;
            m_wr     <= mpick ? M1_WR : M0_WR;
            m_addr   <= mpick ? M1_ADDR : M0_ADDR;
            m_be     <= mpick ? M1_BE : M0_BE;
            m_dout   <= mpick ? M1_DATAO : M0_DATAO;
        end
    end

    initial forever begin
        @(negedge CLK);
        if (chk_en) begin
            check("S_RD", S_RD, m_active && !m_wr);
            check("S_WR", S_WR, m_active && m_wr);
            check("M0_ACK", M0_ACK, m_resp && !m_who);
            check("M1_ACK", M1_ACK, m_resp && m_who);
            check("BUS_ERR", BUS_ERR, m_resp && m_err);
            check("M0_DATAI", M0_DATAI, m_datai[0]);
            check("M1_DATAI", M1_DATAI, m_datai[1]);
            if (m_active) begin
                check("GNT", GNT, m_who);
                check("S_ADDR", S_ADDR, m_addr);
                check("S_BE", S_BE, m_be);
                check("S_DATAO", S_DATAO, m_dout);
            end
        end
    end

    // Slave: mode 0 random latency, 1 never acks, 2 acks after sl_wait_n wait cycles.
    int          sl_mode = 2;
    int          sl_pct = 50;
    int          sl_wait_n = 0;
    int          sl_cnt = 0;
    bit          sl_spur = 1'b0;
    logic [31:0] sl_data = '0;

    initial forever begin
        @(posedge CLK);
        #1;
        if (S_RD || S_WR) begin
            case (sl_mode)
                0:       S_ACK = ($urandom_range(0, 99) < sl_pct);
                1:       S_ACK = 1'b0;
                default: S_ACK = (sl_cnt == sl_wait_n);
            endcase
            sl_cnt++;
        end else begin
            S_ACK  = sl_spur || (sl_mode == 0 && $urandom_range(0, 7) == 0);
            sl_cnt = 0;
        end
        S_DATAI = (sl_mode == 2) ? sl_data : $urandom;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ack(input bit m, input int maxc, output bit got);
        got = 1'b0;
        for (int i = 0; i < maxc && !got; i++) begin
            step();
            got = m ? M1_ACK : M0_ACK;
        end
    endtask

    task automatic rand_req(input logic ack, inout logic rd, inout logic wr, inout logic [3:0] be,
                            inout logic [31:0] addr, inout logic [31:0] dout);
        logic [1:0] op;
        if (ack || ((rd || wr) && $urandom_range(0, 63) == 0)) begin
            rd = 1'b0;
            wr = 1'b0;
        end else if (!(rd || wr) && $urandom_range(0, 2) == 0) begin
            op   = 2'($urandom_range(1, 3));
            rd   = op[0];
            wr   = op[1];
            be   = 4'($urandom);
            addr = $urandom;
            dout = $urandom;
        end
    endtask

    bit got;

    initial begin
        step();
        chk_en = 1'b1;
        step();
        RES = 1'b0;
        check("rst_s_rd", S_RD, 1'b0);
        check("rst_m0_ack", M0_ACK, 1'b0);
        check("rst_m1_datai", M1_DATAI, 32'h0);
        step();

        // Zero-wait M0 read
        sl_data = 32'h12345678; sl_wait_n = 0;
        M0_RD = 1'b1; M0_ADDR = 32'h100; M0_BE = 4'hF;
        step();
        check("t2_s_rd", S_RD, 1'b1);
        check("t2_s_addr", S_ADDR, 32'h100);
        check("t2_gnt", GNT, 1'b0);
        check("t2_ack_early", M0_ACK, 1'b0);
        step();
        check("t2_m0_ack", M0_ACK, 1'b1);
        check("t2_m0_datai", M0_DATAI, 32'h12345678);
        check("t2_bus_err", BUS_ERR, 1'b0);
        M0_RD = 1'b0;
        step();

        // Reset in the middle of a stalled access
        sl_mode = 1;
        M0_WR = 1'b1; M0_ADDR = 32'h104;
        step();
        step();
        RES = 1'b1; M0_WR = 1'b0;
        step();
        step();
        RES = 1'b0;
        check("t1_s_wr", S_WR, 1'b0);
        check("t1_s_rd", S_RD, 1'b0);
        check("t1_bus_err", BUS_ERR, 1'b0);
        check("t1_m0_datai", M0_DATAI, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t1_no_ack", M0_ACK, 1'b0);
        end

        // Tie after reset, then a re-raised M0 ties against pending M1
        sl_mode = 2; sl_wait_n = 0;
        M0_WR = 1'b1; M0_ADDR = 32'hA0; M0_DATAO = 32'hD0; M0_BE = 4'hF;
        M1_WR = 1'b1; M1_ADDR = 32'hA1; M1_DATAO = 32'hD1; M1_BE = 4'hC;
        step();
        check("t3_gnt_first", GNT, 1'b0);
        check("t3_addr_first", S_ADDR, 32'hA0);
        step();
        check("t3_m0_ack", M0_ACK, 1'b1);
        M0_ADDR = 32'hA2; M0_DATAO = 32'hD2;
        step();
        check("t3_idle_gap", S_WR, 1'b0);
        step();
        check("t3_gnt_second", GNT, 1'b1);
        check("t3_addr_second", S_ADDR, 32'hA1);
        step();
        check("t3_m1_ack", M1_ACK, 1'b1);
        M1_WR = 1'b0;
        step();
        step();
        check("t3_gnt_third", GNT, 1'b0);
        check("t3_addr_third", S_ADDR, 32'hA2);
        step();
        check("t3_m0_ack2", M0_ACK, 1'b1);
        M0_WR = 1'b0;
        step();

        // M1 write with three slave wait cycles
        sl_wait_n = 3;
        M1_WR = 1'b1; M1_BE = 4'b0011; M1_ADDR = 32'h200; M1_DATAO = 32'h55AA55AA;
        step();
        for (int i = 0; i < 4; i++) begin
            check("t4_s_wr", S_WR, 1'b1);
            check("t4_s_be", S_BE, 4'b0011);
            check("t4_s_addr", S_ADDR, 32'h200);
            check("t4_no_ack", M1_ACK, 1'b0);
            step();
        end
        check("t4_m1_ack", M1_ACK, 1'b1);
        check("t4_m1_datai", M1_DATAI, 32'h0);
        M1_WR = 1'b0;
        step();

        // Timeout on an unresponsive slave
        sl_mode = 1;
        M0_RD = 1'b1; M0_ADDR = 32'h300;
        for (int j = 1; j <= 17; j++) begin
            step();
            check("t5_no_ack", M0_ACK, 1'b0);
        end
        step();
        check("t5_m0_ack", M0_ACK, 1'b1);
        check("t5_bus_err", BUS_ERR, 1'b1);
        check("t5_m0_datai", M0_DATAI, 32'hDEADBEEF);
        M0_RD = 1'b0;
        sl_mode = 2; sl_wait_n = 1; sl_data = 32'hCAFE0001;
        step();
        M0_RD = 1'b1; M0_ADDR = 32'h304;
        wait_ack(1'b0, 10, got);
        check("t5_next_ack", got, 1'b1);
        check("t5_next_err", BUS_ERR, 1'b0);
        check("t5_next_datai", M0_DATAI, 32'hCAFE0001);
        M0_RD = 1'b0;
        step();

        // Read+write is a write; stray S_ACK in idle does nothing
        sl_spur = 1'b1; sl_wait_n = 0;
        step();
        step();
        check("t6_spur_ack", M0_ACK, 1'b0);
        check("t6_spur_srd", S_RD, 1'b0);
        sl_spur = 1'b0;
        M0_RD = 1'b1; M0_WR = 1'b1; M0_ADDR = 32'h400;
        step();
        check("t6_s_wr", S_WR, 1'b1);
        check("t6_s_rd", S_RD, 1'b0);
        step();
        check("t6_m0_ack", M0_ACK, 1'b1);
        check("t6_m0_datai", M0_DATAI, 32'hCAFE0001);
        M0_RD = 1'b0; M0_WR = 1'b0;
        step();

        // Randomized traffic against the reference
        sl_mode = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) sl_pct = ((c / 500) % 4 == 3) ? 0 : $urandom_range(25, 100);
            RES = ($urandom_range(0, 799) == 0);
            rand_req(M0_ACK, M0_RD, M0_WR, M0_BE, M0_ADDR, M0_DATAO);
            rand_req(M1_ACK, M1_RD, M1_WR, M1_BE, M1_ADDR, M1_DATAO);
            step();
        end
        RES = 1'b0;
        M0_RD = 1'b0; M0_WR = 1'b0; M1_RD = 1'b0; M1_WR = 1'b0;
        for (int i = 0; i < 25; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
